// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, valid/ready imem port, redirect/flush, decode queue.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects queue a trap NOP and halt fetch.
module fetch_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [11:0]     out_imm,
  output logic [PC_W-1:0] fetch_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            out_misalign
`endif
);

  localparam int unsigned     PtrW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned     CntW      = PtrW + 1;
  localparam logic [CntW-1:0] QDepthCnt = CntW'(QDEPTH);
  localparam logic [31:0]     TrapNop   = 32'h0000_0013;

  // Architectural state
  logic [PC_W-1:0] pc_q, pc_d;
  logic            outstanding_q, outstanding_d;
  logic            stale_q, stale_d;
  logic [PC_W-1:0] req_addr_q, req_addr_d;

  // Queue state
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PC_W-1:0] q_pc    [QDEPTH];
  logic [31:0]     q_instr [QDEPTH];

  // Queue write port
  logic            wr_en;
  logic [PtrW-1:0] wr_idx;
  logic [PC_W-1:0] wr_pc;
  logic [31:0]     wr_instr;

  // Control strobes
  logic            fetch_en;
  logic            req_hs;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] redir_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            q_mis [QDEPTH];
  logic            wr_mis;
  logic            halt_q, halt_d;
  logic            redir_mis;

  assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_tgt = redirect_pc;
  assign fetch_en  = !halt_q;
`else
  assign redir_tgt = redirect_pc & ~PC_W'(3);
  assign fetch_en  = 1'b1;
`endif

  // The credit check counts the in-flight request too, but that request already
  // blocks issue through outstanding_q, so the queue occupancy alone suffices here.
  assign imem_req_valid = !rst && !outstanding_q && !redirect_valid && fetch_en &&
                          (count_q < QDepthCnt);
  assign imem_req_addr  = pc_q;
  assign fetch_pc       = pc_q;

  assign req_hs   = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && outstanding_q;
  assign push     = rsp_take && !stale_q && !redirect_valid;
  assign out_valid = (count_q != '0);
  assign pop      = out_valid && out_ready && !redirect_valid;

  // PC and request tracking
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    req_addr_d    = req_addr_q;

    if (redirect_valid) begin
      pc_d = redir_tgt;
    end else if (req_hs) begin
      pc_d = pc_q + PC_W'(4);
    end

    if (req_hs) begin
      outstanding_d = 1'b1;
      req_addr_d    = pc_q;
    end else if (rsp_take) begin
      outstanding_d = 1'b0;
    end

    // A response returning in the redirect cycle is simply dropped; only a
    // request still in flight needs to be marked stale.
    if (rsp_take) begin
      stale_d = 1'b0;
    end else if (redirect_valid && outstanding_q) begin
      stale_d = 1'b1;
    end
  end

  // Queue pointers and write port
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    wr_idx   = wr_ptr_q;
    wr_pc    = req_addr_q;
    wr_instr = imem_rsp_data;
`ifdef FETCH_MISALIGN_TRAP_EN
    wr_mis   = 1'b0;
    halt_d   = halt_q;
`endif

    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_d   = redir_mis;
      if (redir_mis) begin
        wr_en    = 1'b1;
        wr_idx   = '0;
        wr_pc    = redirect_pc;
        wr_instr = TrapNop;
        wr_mis   = 1'b1;
        wr_ptr_d = PtrW'(1);
        count_d  = CntW'(1);
      end
`endif
    end else begin
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      stale_q       <= 1'b0;
      req_addr_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q        <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      req_addr_q    <= req_addr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q        <= halt_d;
`endif
    end
  end

  // Entry storage needs no reset: the read side is gated by count_q.
  always_ff @(posedge CLK) begin
    if (wr_en && !rst) begin
      q_pc[wr_idx]    <= wr_pc;
      q_instr[wr_idx] <= wr_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
      q_mis[wr_idx]   <= wr_mis;
`endif
    end
  end

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (out_valid) begin
      out_pc    = q_pc[rd_ptr_q];
      out_instr = q_instr[rd_ptr_q];
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign out_misalign = out_valid && q_mis[rd_ptr_q];
`endif

  assign out_rd  = out_instr[11:7];
  assign out_rs1 = out_instr[19:15];
  assign out_rs2 = out_instr[24:20];
  assign out_imm = out_instr[31:20];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus randomized traffic against a queue-based model.
module tb_fetch_unit;

  localparam int unsigned     PC_W     = 8;
  localparam int unsigned     QDEPTH   = 2;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  logic            CLK = 1'b0;
  logic            rst = 1'b1;
  logic            redirect_valid = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [PC_W-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [11:0]     out_imm;
  logic [PC_W-1:0] fetch_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            out_misalign;
`endif

  always #5 CLK = ~CLK;

  fetch_unit #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC),
    .QDEPTH  (QDEPTH)
  ) dut (
    .CLK           (CLK),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_imm       (out_imm),
    .fetch_pc      (fetch_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .out_misalign  (out_misalign)
`endif
  );

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] mem_arr [64];
  int          checks = 0;
  int          errors = 0;

  // Memory-side and model state
  bit          pend = 0, pend_stale = 0, orphan = 0;
  int          pend_cnt = 0;
  logic [7:0]  pend_addr = '0;
  int          lat = 1;
  bit          rand_ready = 0;
  logic [7:0]  exp_pc = RESET_PC;
  bit          halted = 0;
  bit          just_reset = 0;
  bit          hs_seen = 0;
  logic [7:0]  hs_addr = '0;
  bit          wrapped = 0, dec_seen = 0;
  logic [7:0]  last_pop_pc = '0;
  bit          stall_chk = 0;
  bit          arm_first = 0, first_done = 0;
  logic [7:0]  first_pc_exp = '0;

  // Next-cycle stimulus, applied at the falling edge
  bit          nx_rst = 1, nx_redir = 0, nx_oready = 0;
  logic [7:0]  nx_tgt = '0;

  function automatic logic [31:0] word(input logic [7:0] a);
    return mem_arr[a[7:2]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic       s_rv;
    logic [7:0] s_ra;
    bit         exp_rv, hs, rsp, pop, was_stale, was_orphan;
    ent_t       e;
    @(negedge CLK);
    rst            = nx_rst;
    redirect_valid = nx_redir;
    redirect_pc    = nx_tgt;
    out_ready      = nx_oready;
    imem_req_ready = orphan ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    if (pend && pend_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    exp_rv = !rst && !(pend && !orphan) && !redirect_valid && !halted &&
             (exp_q.size() < QDEPTH);
    chk("req_valid", imem_req_valid, exp_rv);
    chk("fetch_pc", fetch_pc, exp_pc);
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (just_reset) begin
      chk("reset_out_pc", out_pc, 0);
      chk("reset_out_instr", out_instr, 0);
    end
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk("out_pc", out_pc, e.pc);
      chk("out_instr", out_instr, e.instr);
      chk("out_rd", out_rd, e.instr[11:7]);
      chk("out_rs1", out_rs1, e.instr[19:15]);
      chk("out_rs2", out_rs2, e.instr[24:20]);
      chk("out_imm", out_imm, e.instr[31:20]);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("out_misalign", out_misalign, e.mis);
`endif
      if (e.pc == 8'h20 && !e.mis) begin
        chk("dec_rd", out_rd, 13);
        chk("dec_rs1", out_rs1, 10);
        chk("dec_rs2", out_rs2, 4);
        chk("dec_imm", out_imm, 12'h004);
        dec_seen = 1;
      end
    end
    if (stall_chk) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_req_valid", imem_req_valid, 0);
      stall_chk = 0;
    end
    if (arm_first && out_valid) begin
      chk("first_pc_after_redirect", out_pc, first_pc_exp);
      arm_first  = 0;
      first_done = 1;
    end
    s_rv = imem_req_valid;
    s_ra = imem_req_addr;
    @(posedge CLK);
    hs         = s_rv && imem_req_ready;
    rsp        = imem_rsp_valid;
    pop        = (exp_q.size() != 0) && out_ready && !redirect_valid;
    was_stale  = pend_stale;
    was_orphan = orphan;
    hs_seen    = 0;
    if (rsp) begin
      pend = 0; pend_stale = 0; orphan = 0;
    end else if (pend) begin
      pend_cnt--;
    end
    if (rst) begin
      exp_q.delete();
      exp_pc     = RESET_PC;
      halted     = 0;
      pend_stale = 0;
      if (pend) orphan = 1;
      just_reset = 1;
    end else begin
      just_reset = 0;
      if (pop) begin
        if (exp_q[0].pc == 8'h00 && last_pop_pc == 8'hFC) wrapped = 1;
        last_pop_pc = exp_q[0].pc;
        void'(exp_q.pop_front());
      end
      if (rsp && !was_stale && !was_orphan && !redirect_valid) begin
        e.pc = pend_addr; e.instr = word(pend_addr); e.mis = 1'b0;
        exp_q.push_back(e);
      end
      if (redirect_valid) begin
        exp_q.delete();
        if (pend) pend_stale = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_pc = redirect_pc;
        halted = (redirect_pc[1:0] != 2'b00);
        if (halted) begin
          e.pc = redirect_pc; e.instr = 32'h0000_0013; e.mis = 1'b1;
          exp_q.push_back(e);
        end
`else
        exp_pc = redirect_pc & 8'hFC;
`endif
      end else if (hs) begin
        exp_pc     = exp_pc + 8'd4;
        pend       = 1;
        pend_addr  = s_ra;
        pend_cnt   = lat - 1;
        pend_stale = 0;
        hs_seen    = 1;
        hs_addr    = s_ra;
      end
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
    mem_arr[8] = 32'h0045_0693;

    // Reset
    nx_rst = 1; nx_oready = 1;
    cycle(); cycle();
    nx_rst = 0;

    // Sequential fetch with 1-cycle memory, through the 0xFC -> 0x00 wrap
    lat = 1; rand_ready = 0;
    for (int i = 0; i < 150; i++) cycle();
    chk("pc_wrap_seen", wrapped, 1);
    chk("decode_example_seen", dec_seen, 1);

    // Decoder stall: queue fills, fetch stops, then drains in order
    nx_oready = 0;
    for (int i = 0; i < 10; i++) cycle();
    stall_chk = 1;
    cycle();
    nx_oready = 1;
    for (int i = 0; i < 10; i++) cycle();

    // Redirect one cycle after a handshake at 0x10 with 3-cycle latency
    lat = 3;
    nx_redir = 1; nx_tgt = 8'h10;
    cycle();
    nx_redir = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = hs_seen && (hs_addr == 8'h10);
    end
    chk("hs_at_0x10", found, 1);
    nx_redir = 1; nx_tgt = 8'h40;
    arm_first = 1; first_pc_exp = 8'h40; first_done = 0;
    cycle();
    nx_redir = 0;
    for (int i = 0; i < 30 && !first_done; i++) cycle();
    chk("first_pc_reached", first_done, 1);

    // Randomized traffic with variable latency, backpressure, redirects, resets
    rand_ready = 1;
    for (int i = 0; i < 1500; i++) begin
      lat       = $urandom_range(1, 4);
      nx_oready = ($urandom_range(0, 9) < 7);
      nx_redir  = ($urandom_range(0, 19) == 0);
      nx_tgt    = 8'($urandom) & 8'hFC;
`ifndef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(0, 3) == 0) nx_tgt = 8'($urandom);
`endif
      nx_rst    = ($urandom_range(0, 299) == 0);
      cycle();
    end
    nx_rst = 0; nx_redir = 0; nx_oready = 1;
    for (int i = 0; i < 10; i++) cycle();

    // Reset with a non-empty queue and a request in flight; late response ignored
    rand_ready = 0; lat = 3; nx_oready = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = (exp_q.size() >= 1) && pend && !pend_stale;
    end
    chk("reset_setup_reached", found, 1);
    nx_rst = 1;
    cycle();
    nx_rst = 0;
    for (int i = 0; i < 12; i++) cycle();
    nx_oready = 1;
    for (int i = 0; i < 10; i++) cycle();

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect queues a trap entry and halts until an aligned redirect
    lat = 1; nx_oready = 0;
    nx_redir = 1; nx_tgt = 8'h42;
    arm_first = 1; first_pc_exp = 8'h42;
    cycle();
    nx_redir = 0;
    for (int i = 0; i < 6; i++) cycle();
    nx_oready = 1;
    for (int i = 0; i < 4; i++) cycle();
    nx_redir = 1; nx_tgt = 8'h44;
    arm_first = 1; first_pc_exp = 8'h44; first_done = 0;
    cycle();
    nx_redir = 0;
    for (int i = 0; i < 10; i++) cycle();
    chk("aligned_resume", first_done, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end. It replaces the fixed 8-bit PC / +4 adder / combinational ROM loop with four pieces:
- a PC register of configurable width and reset vector
- a valid/ready instruction-memory request/response interface that tolerates variable latency
- branch/jump redirect with flush
- a QDEPTH-entry instruction queue feeding the decoder, with rd/rs1/rs2/imm fields extracted

Sits between instruction memory and decode/execute.

Parameters:
PC_W, 32, program-counter and address width (≥8)
RESET_PC, 0, PC value loaded on reset
QDEPTH, 2, instruction queue entries (power of two, ≥2)

Ports:
CLK  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  PC_W  redirect target
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  PC_W  fetch address (= PC)
imem_rsp_valid  in  1  response data valid (no backpressure)
imem_rsp_data  in  32  fetched instruction
out_valid  out  1  queue head valid
out_ready  in  1  decoder consumes head
out_pc  out  PC_W  PC of head instruction
out_instr  out  32  head instruction
out_rd  out  5  out_instr[11:7]
out_rs1  out  5  out_instr[19:15]
out_rs2  out  5  out_instr[24:20]
out_imm  out  12  out_instr[31:20]
fetch_pc  out  PC_W  current PC register (debug)

Behaviour:
- Reset (rst=1 at edge):
  - PC<=RESET_PC; queue empty; outstanding=0; stale=0.
  - out_valid=0, out_pc/out_instr=0.
  - imem_req_valid forced 0 while rst=1.
- Request issue (combinational): imem_req_valid = !rst && !outstanding && !redirect_valid && (count < QDEPTH).
  - At most one request is outstanding.
  - imem_req_addr=PC, held stable while valid && !ready.
  - Handshake (valid&&ready): PC<=PC+4 (mod 2^PC_W wrap); outstanding<=1; the issued address is stored for the response.
- Response: imem_rsp_valid with outstanding=1 and stale=0 pushes {addr,data} into the queue and clears outstanding.
  - Response with stale=1 is dropped; clears outstanding and stale.
  - imem_rsp_valid while outstanding=0 is ignored.
  - Response in the same cycle as the request handshake is illegal (min latency 1 cycle).
- Credit rule: a request is issued only if count < QDEPTH, with count including the outstanding one. Overflow is therefore impossible.
- Queue:
  - out_valid = count>0; out_* reflect the head; pop on out_valid&&out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo QDEPTH.
  - Latency: response at edge N → out_valid=1 after edge N.
- Redirect (redirect_valid=1 at edge):
  - PC<=redirect_pc; queue flushed (count<=0, out_valid=0 next cycle).
  - If outstanding (or an outstanding response arrives that same cycle), stale<=1 / response dropped.
  - Any pop that same cycle is discarded.
  - Request withdrawal: imem_req_valid drops during a redirect cycle. The memory interface permits withdrawal only on redirect.
  - Next request issues the cycle after the redirect, with addr=redirect_pc, once any stale response has returned.
- Redirect during rst: rst wins.
- Decoder fields are pure slices of out_instr. No immediate sign extension.

Optional Feature:
FETCH_MISALIGN_TRAP_EN:
- Defined:
  - Adds output out_misalign (1 bit).
  - Redirect with redirect_pc[1:0]!=0 performs the normal flush, then queues one entry: pc=redirect_pc, instr=32'h00000013, misalign=1.
  - Fetching then halts (imem_req_valid=0) until the next aligned redirect or reset.
- Undefined:
  - out_misalign is absent.
  - redirect_pc[1:0] is forced to 2'b00 before loading PC.

Test Plan:
1. PC_W=8, RESET_PC=0, 1-cycle memory returning addr-indexed words, out_ready=1 → out_pc sequence 0x00,0x04,0x08…; 0xFC wraps to 0x00.
2. Instruction 32'h00450693 at head → out_rd=13, out_rs1=10, out_rs2=4, out_imm=12'h004.
3. out_ready=0 for 10 cycles, QDEPTH=2:
   - count saturates at 2, imem_req_valid=0, PC frozen.
   - out_ready=1 → drains in order, fetch resumes.
4. Memory latency 3, redirect_pc=0x40 one cycle after the handshake at 0x10:
   - 0x10 response dropped, queue empty.
   - Next request addr=0x40; first out_pc=0x40.
5. Assert rst while queue holds 2 entries and a request is outstanding → next cycle out_valid=0, fetch_pc=RESET_PC; subsequent late response is ignored.
6. (FETCH_MISALIGN_TRAP_EN) redirect_pc=0x42 → single entry out_pc=0x42, out_misalign=1, out_instr=0x00000013; no requests until redirect_pc=0x44.
